// File: rtl/sram_frame_reader.sv
// sram_frame_reader
// -----------------
// Read side of the SRAM frame buffer. Once per frame, this block streams an
// RGB565 image from SRAM in raster order. Each pixel is expanded to 8-bit
// channels and presented through a small prefetch FIFO. Reads are issued only
// in cycles where the external arbiter grants the bus. SRAM read data is
// captured on the edge that ends the issue cycle, so a read is never left in
// flight across an edge.
//
// Ports
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_frame_start           : one-cycle pulse that starts or restarts a frame
//   i_grant                 : this block owns the SRAM bus this cycle
//   o_SRAM_ADDR, i_SRAM_DQ  : SRAM word address and read data
//   o_SRAM_*_N              : SRAM controls, active-low (WE_N is held high)
//   i_pix_req               : consumer takes the head pixel this cycle
//   o_valid, o_red/green/blue : head pixel; channels read 0 when not valid
//   o_frame_done            : pulse in the cycle after the final pixel is popped
//   o_underflow             : sticky flag, set on a request to an empty FIFO
`timescale 1ns/1ps
module sram_frame_reader #(
  parameter int BASE_ADDR  = 0,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_start,
  input  logic        i_grant,
  output logic [19:0] o_SRAM_ADDR,
  input  logic [15:0] i_SRAM_DQ,
  output logic        o_SRAM_CE_N,
  output logic        o_SRAM_OE_N,
  output logic        o_SRAM_WE_N,
  output logic        o_SRAM_LB_N,
  output logic        o_SRAM_UB_N,
  input  logic        i_pix_req,
  output logic        o_valid,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        o_frame_done,
  output logic        o_underflow
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [18:0] TOTAL   = 19'(H_ACTIVE * V_ACTIVE);
  localparam logic [18:0] LAST    = TOTAL - 19'd1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [18:0]   rd_idx_q, rd_idx_d;
  logic [18:0]   pop_idx_q, pop_idx_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          underflow_q, underflow_d;
  logic          frame_done_q, frame_done_d;
  logic [19:0]   addr_q, addr_d;
  logic [15:0]   mem [FIFO_DEPTH];

  logic          active;
  logic          pop;
  logic          issue;
  logic [19:0]   issue_addr;
  logic [15:0]   head;

  assign active = (state_q == S_FETCH) || (state_q == S_DRAIN);

  // A frame-start cycle does neither a pop nor an issue. This ensures the
  // flushed FIFO restarts cleanly, with word 0 as the first read.
  assign pop   = active && i_pix_req && (count_q != '0) && !i_frame_start;
  assign issue = (state_q == S_FETCH) && i_grant && !i_frame_start &&
                 ((count_q < DEPTH_C) || pop);

  // 20-bit addition wraps modulo 2^20.
  assign issue_addr = 20'(BASE_ADDR) + {1'b0, rd_idx_q};

  // NOTE: every variable gets a default at the top of always_comb, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    rd_idx_d     = rd_idx_q;
    pop_idx_d    = pop_idx_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    underflow_d  = underflow_q;
    frame_done_d = 1'b0;
    addr_d       = addr_q;

    if (i_frame_start) begin
      state_d     = S_FETCH;
      rd_idx_d    = '0;
      pop_idx_d   = '0;
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      underflow_d = 1'b0;
    end else begin
      if (issue) begin
        rd_idx_d = rd_idx_q + 19'd1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        addr_d   = issue_addr;
        if (rd_idx_q == LAST) state_d = S_DRAIN;
      end
      if (pop) begin
        pop_idx_d = pop_idx_q + 19'd1;
        rd_ptr_d  = rd_ptr_q + AW'(1);
        // The last pop can only happen in DRAIN, because every read was
        // issued on an earlier edge.
        if ((state_q == S_DRAIN) && (pop_idx_q == LAST)) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      case ({issue, pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
      if (active && i_pix_req && (count_q == '0)) underflow_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      rd_idx_q     <= '0;
      pop_idx_q    <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      rd_idx_q     <= rd_idx_d;
      pop_idx_q    <= pop_idx_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      underflow_q  <= underflow_d;
      frame_done_q <= frame_done_d;
      addr_q       <= addr_d;
    end
  end

  // NOTE: the FIFO storage has no reset. Its contents are never observed
  // while count is 0, and the channel outputs are masked by o_valid.
  always_ff @(posedge i_clk) begin
    if (issue) mem[wr_ptr_q] <= i_SRAM_DQ;
  end

  assign head    = mem[rd_ptr_q];
  assign o_valid = (count_q != '0);

  // RGB565 to 8 bits per channel: the top bits are replicated into the LSBs.
  assign o_red   = o_valid ? {head[15:11], head[15:13]} : 8'h00;
  assign o_green = o_valid ? {head[10:5],  head[10:9]}  : 8'h00;
  assign o_blue  = o_valid ? {head[4:0],   head[4:2]}   : 8'h00;

  // The address bus holds the last issued address between reads.
  assign o_SRAM_ADDR  = issue ? issue_addr : addr_q;
  assign o_SRAM_CE_N  = ~issue;
  assign o_SRAM_OE_N  = ~issue;
  assign o_SRAM_LB_N  = ~issue;
  assign o_SRAM_UB_N  = ~issue;
  assign o_SRAM_WE_N  = 1'b1;

  assign o_frame_done = frame_done_q;
  assign o_underflow  = underflow_q;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Directed testbench for sram_frame_reader: H_ACTIVE=4, V_ACTIVE=2,
// FIFO_DEPTH=4, BASE_ADDR=0x100. The SRAM model returns word k = 16'hF800+k
// at address 0x100+k. Inputs are driven on the falling edge, and outputs are
// sampled 1 ns later, well away from the rising edge.
`timescale 1ns/1ps
module tb_sram_frame_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        grant = 1'b0;
  logic        pix_req = 1'b0;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;
  logic        valid, frame_done, underflow;
  logic [7:0]  red, green, blue;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign sram_dq = 16'hF800 + (sram_addr[15:0] - 16'h0100);

  sram_frame_reader #(
    .BASE_ADDR (32'h100),
    .H_ACTIVE  (4),
    .V_ACTIVE  (2),
    .FIFO_DEPTH(4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_frame_start(frame_start),
    .i_grant      (grant),
    .o_SRAM_ADDR  (sram_addr),
    .i_SRAM_DQ    (sram_dq),
    .o_SRAM_CE_N  (ce_n),
    .o_SRAM_OE_N  (oe_n),
    .o_SRAM_WE_N  (we_n),
    .o_SRAM_LB_N  (lb_n),
    .o_SRAM_UB_N  (ub_n),
    .i_pix_req    (pix_req),
    .o_valid      (valid),
    .o_red        (red),
    .o_green      (green),
    .o_blue       (blue),
    .o_frame_done (frame_done),
    .o_underflow  (underflow)
  );

  // Reference RGB565 to 888 expansion of word w.
  function automatic logic [23:0] expand(input logic [15:0] w);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = w[15:11];
    g6 = w[10:5];
    b5 = w[4:0];
    return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
  endfunction

  task automatic cycle_begin();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle_begin(); cycle_begin();
    settle();
    checks++;
    if ({valid, frame_done, underflow} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got valid/done/uf=%b want 000", {valid, frame_done, underflow});
    end
    checks++;
    if (sram_addr !== 20'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h want 00000", sram_addr);
    end
    checks++;
    if ({ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 11111", {ce_n, oe_n, we_n, lb_n, ub_n});
    end
    checks++;
    if ({red, green, blue} !== 24'h0) begin
      errors++;
      $display("FAIL reset_pixel: got %h want 000000", {red, green, blue});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [19:0] iss_addr [$];
    int          iss_cyc  [$];
    logic [23:0] pix      [$];
    int done_cnt = 0;
    int done_cyc = -1;
    grant = 1'b1;
    for (int c = 0; c < 14; c++) begin
      cycle_begin();
      frame_start = (c == 0);
      pix_req     = (c >= 2 && c <= 9);
      settle();
      if (!ce_n) begin iss_addr.push_back(sram_addr); iss_cyc.push_back(c); end
      if (valid && pix_req) pix.push_back({red, green, blue});
      if (frame_done) begin done_cnt++; done_cyc = c; end
    end
    pix_req = 1'b0;
    checks++;
    if (iss_addr.size() != 8) begin
      errors++;
      $display("FAIL single_issue_count: got %0d want 8", iss_addr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (iss_addr[i] !== 20'h100 + 20'(i) || iss_cyc[i] != i + 1) begin
          errors++;
          $display("FAIL single_issue_%0d: got addr %h cyc %0d want %h cyc %0d",
                   i, iss_addr[i], iss_cyc[i], 20'h100 + 20'(i), i + 1);
        end
      end
    end
    checks++;
    if (pix.size() != 8) begin
      errors++;
      $display("FAIL single_pop_count: got %0d want 8", pix.size());
    end else begin
      checks++;
      if (pix[0] !== 24'hFF0000) begin
        errors++;
        $display("FAIL single_pixel0: got %h want ff0000", pix[0]);
      end
      checks++;
      if (pix[1][7:0] !== 8'h08) begin
        errors++;
        $display("FAIL single_pixel1_blue: got %h want 08", pix[1][7:0]);
      end
      for (int i = 2; i < 8; i++) begin
        checks++;
        if (pix[i] !== expand(16'hF800 + 16'(i))) begin
          errors++;
          $display("FAIL single_pixel%0d: got %h want %h", i, pix[i], expand(16'hF800 + 16'(i)));
        end
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 10) begin
      errors++;
      $display("FAIL single_frame_done: got %0d pulses at cyc %0d want 1 at cyc 10", done_cnt, done_cyc);
    end
    checks++;
    if (dut.state_q !== 2'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got state %0d valid %b want 0 0", dut.state_q, valid);
    end
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL single_underflow: got %b want 0", underflow);
    end
  endtask

  task automatic test_backpressure();
    int issues = 0;
    grant   = 1'b1;
    pix_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cycle_begin();
      frame_start = (c == 0);
      settle();
      if (!ce_n) issues++;
    end
    frame_start = 1'b0;
    checks++;
    if (issues != 4) begin
      errors++;
      $display("FAIL bp_issue_count: got %0d want 4", issues);
    end
    checks++;
    if (ce_n !== 1'b1 || oe_n !== 1'b1 || dut.count_q !== 3'd4) begin
      errors++;
      $display("FAIL bp_full_idle: got ce %b oe %b count %0d want 1 1 4", ce_n, oe_n, dut.count_q);
    end
    cycle_begin();
    pix_req = 1'b1;
    settle();
    checks++;
    if (ce_n !== 1'b0 || sram_addr !== 20'h104 || {red, green, blue} !== 24'hFF0000) begin
      errors++;
      $display("FAIL bp_pop_issue: got ce %b addr %h pix %h want 0 00104 ff0000", ce_n, sram_addr, {red, green, blue});
    end
    cycle_begin();
    pix_req = 1'b0;
    settle();
    checks++;
    if (ce_n !== 1'b1 || dut.count_q !== 3'd4 || blue !== 8'h08) begin
      errors++;
      $display("FAIL bp_after_pop: got ce %b count %0d blue %h want 1 4 08", ce_n, dut.count_q, blue);
    end
  endtask

  task automatic test_grant_gaps();
    logic [19:0] iss_addr [$];
    logic [23:0] pix      [$];
    int bad_issue = 0;
    int done_cnt  = 0;
    for (int c = 0; c < 30; c++) begin
      cycle_begin();
      frame_start = (c == 0);
      grant       = (c % 2 == 1);
      pix_req     = valid;
      settle();
      if (!ce_n) begin
        iss_addr.push_back(sram_addr);
        if (!grant) bad_issue++;
      end
      if (valid && pix_req && c != 0) pix.push_back({red, green, blue});
      if (frame_done) done_cnt++;
    end
    pix_req = 1'b0;
    checks++;
    if (bad_issue != 0 || iss_addr.size() != 8) begin
      errors++;
      $display("FAIL gap_issues: got %0d ungranted, %0d total want 0, 8", bad_issue, iss_addr.size());
    end
    checks++;
    if (pix.size() != 8) begin
      errors++;
      $display("FAIL gap_pop_count: got %0d want 8", pix.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (pix[i] !== expand(16'hF800 + 16'(i)) || iss_addr[i] !== 20'h100 + 20'(i)) begin
          errors++;
          $display("FAIL gap_pixel%0d: got pix %h addr %h want %h %h", i, pix[i], iss_addr[i],
                   expand(16'hF800 + 16'(i)), 20'h100 + 20'(i));
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL gap_frame_done: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_underflow();
    int stray = 0;
    grant = 1'b0;
    cycle_begin(); frame_start = 1'b1; pix_req = 1'b0;
    cycle_begin(); frame_start = 1'b0; pix_req = 1'b1;
    settle(); if (!ce_n) stray++;
    cycle_begin(); pix_req = 1'b0;
    settle(); if (!ce_n) stray++;
    checks++;
    if (underflow !== 1'b1 || valid !== 1'b0 || {red, green, blue} !== 24'h0) begin
      errors++;
      $display("FAIL uf_set: got uf %b valid %b pix %h want 1 0 000000", underflow, valid, {red, green, blue});
    end
    checks++;
    if (dut.pop_idx_q !== 19'd0) begin
      errors++;
      $display("FAIL uf_pop_idx: got %0d want 0", dut.pop_idx_q);
    end
    cycle_begin(); cycle_begin();
    settle(); if (!ce_n) stray++;
    checks++;
    if (underflow !== 1'b1 || stray != 0) begin
      errors++;
      $display("FAIL uf_sticky: got uf %b stray issues %0d want 1 0", underflow, stray);
    end
    cycle_begin(); frame_start = 1'b1;
    cycle_begin(); frame_start = 1'b0;
    settle();
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_cleared: got %b want 0", underflow);
    end
  endtask

  task automatic test_restart();
    logic [23:0] pre  [$];
    logic [23:0] post [$];
    int done_cnt = 0;
    grant = 1'b1;
    for (int c = 0; c < 31; c++) begin
      cycle_begin();
      frame_start = (c == 0) || (c == 5);
      if (c <= 5)      pix_req = (c >= 2);
      else if (c == 6) pix_req = 1'b0;
      else             pix_req = valid;
      settle();
      if (c >= 2 && c <= 4 && valid) pre.push_back({red, green, blue});
      if (c >= 7 && valid && pix_req) post.push_back({red, green, blue});
      if (frame_done) done_cnt++;
      if (c == 6) begin
        checks++;
        if (valid !== 1'b0 || ce_n !== 1'b0 || sram_addr !== 20'h100) begin
          errors++;
          $display("FAIL rs_flush: got valid %b ce %b addr %h want 0 0 00100", valid, ce_n, sram_addr);
        end
      end
    end
    pix_req = 1'b0;
    checks++;
    if (pre.size() != 3 || pre[2] !== expand(16'hF802)) begin
      errors++;
      $display("FAIL rs_pre_pops: got %0d pops want 3 ending at word 2", pre.size());
    end
    checks++;
    if (post.size() != 8 || post[0] !== 24'hFF0000) begin
      errors++;
      $display("FAIL rs_post: got %0d pops first %h want 8 ff0000", post.size(), post.size() > 0 ? post[0] : 24'h0);
    end
    checks++;
    if (done_cnt != 1 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL rs_done: got %0d pulses uf %b want 1 0", done_cnt, underflow);
    end
  endtask

  task automatic test_idle_reset();
    int stray = 0;
    grant = 1'b1;
    pix_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle_begin();
      settle();
      if (!ce_n) stray++;
    end
    checks++;
    if (stray != 0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL idle_req: got %0d issues uf %b want 0 0", stray, underflow);
    end
    cycle_begin(); frame_start = 1'b1; pix_req = 1'b0;
    cycle_begin(); frame_start = 1'b0; pix_req = 1'b1;
    cycle_begin(); pix_req = 1'b0;
    settle();
    checks++;
    if (underflow !== 1'b1 || valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_precond: got uf %b valid %b want 1 1", underflow, valid);
    end
    cycle_begin(); rst = 1'b1;
    cycle_begin(); rst = 1'b0;
    settle();
    checks++;
    if ({valid, frame_done, underflow} !== 3'b000 || sram_addr !== 20'h0 ||
        {ce_n, oe_n, we_n, lb_n, ub_n} !== 5'b11111 || {red, green, blue} !== 24'h0 ||
        dut.state_q !== 2'd0) begin
      errors++;
      $display("FAIL rst_midfetch: got flags %b addr %h ctrl %b pix %h state %0d want 000 00000 11111 000000 0",
               {valid, frame_done, underflow}, sram_addr, {ce_n, oe_n, we_n, lb_n, ub_n},
               {red, green, blue}, dut.state_q);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_grant_gaps();
    test_underflow();
    test_restart();
    test_idle_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
